lzss_enc_token: RTL

LZSS_ENC_TOKEN -- requirements
Module: lzss_enc_token

---
 rtl/lzss_enc_token_pkg.sv | 16 +
 rtl/lzss_enc_token_reg.sv | 37 +++
 rtl/lzss_enc_token.sv | 112 +++++++++++
 3 files changed

// File: rtl/lzss_enc_token_pkg.sv
// Shared LZSS encoder definitions: token FSM encoding, default minimum match
// length and the token payload width derivation.
package lzss_enc_token_pkg;

  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_SKIP = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int LZSS_MIN_MATCH = 2;

  // Payload must carry either a literal byte or a packed {offset,length} pair.
  function automatic int lzss_code_width(input int data_w, input int off_w, input int len_w);
    return (data_w > off_w + len_w) ? data_w : off_w + len_w;
  endfunction

endpackage

// File: rtl/lzss_enc_token_reg.sv
// One-entry token output register; holds its contents while the consumer stalls.
module lzss_enc_token_reg #(
  parameter int pCodeWidth = 9
) (
  input  logic                  clk,
  input  logic                  rst_x,
  input  logic                  clear,
  input  logic                  load,
  input  logic                  ready,
  input  logic                  load_flag,
  input  logic [pCodeWidth-1:0] load_code,
  input  logic                  load_last,
  output logic                  valid,
  output logic                  flag,
  output logic [pCodeWidth-1:0] code,
  output logic                  last
);

  always_ff @(posedge clk) begin
    if (!rst_x) begin
      valid <= 1'b0;
      flag  <= 1'b0;
      code  <= '0;
      last  <= 1'b0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      flag  <= load_flag;
      code  <= load_code;
      last  <= load_last;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/lzss_enc_token.sv
// LZSS token emitter: turns per-position match results into literal/match tokens,
// skipping the positions covered by an emitted match.
module lzss_enc_token
  import lzss_enc_token_pkg::*;
#(
  parameter int pDataWidth   = 8,
  parameter int pOffsetWidth = 6,
  parameter int pLengthWidth = 3,
  parameter int pMinMatch    = LZSS_MIN_MATCH,
  parameter int pCodeWidth   = lzss_code_width(pDataWidth, pOffsetWidth, pLengthWidth)
) (
  input  logic                    clk,
  input  logic                    rst_x,
  input  logic                    i_clear,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [pDataWidth-1:0]   i_data,
  input  logic [pOffsetWidth-1:0] i_offset,
  input  logic [pLengthWidth-1:0] i_length,
  input  logic                    i_last,
  input  logic                    i_eos,
  output logic                    o_update,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic                    o_flag,
  output logic [pCodeWidth-1:0]   o_code,
  output logic                    o_last
);

  localparam logic [pLengthWidth-1:0] MIN_LEN = pLengthWidth'(pMinMatch);
  localparam logic [pLengthWidth-1:0] ONE     = pLengthWidth'(1);

  logic [1:0]              state_reg, state_next;
  logic [pLengthWidth-1:0] cnt_reg, cnt_next;
  logic                    acc, load, is_match, tok_last;
  logic [pCodeWidth-1:0]   tok_code;

  // Only RUN can back-pressure; skipped and post-stream beats are always absorbed.
  assign o_ready  = (state_reg == ST_RUN) ? (!o_valid || i_ready) : 1'b1;
  assign acc      = i_valid & o_ready;
  assign o_update = acc;

  assign load     = acc && (state_reg == ST_RUN) && !i_clear;
  assign is_match = (i_length >= MIN_LEN);
  assign tok_last = is_match ? i_last : i_eos;
  assign tok_code = is_match ? pCodeWidth'({i_offset, i_length}) : pCodeWidth'(i_data);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_RUN: begin
        if (load) begin
          if (tok_last) begin
            state_next = ST_DONE;
          end else if (is_match && (i_length > ONE)) begin
            cnt_next   = i_length - ONE;
            state_next = ST_SKIP;
          end
        end
      end
      ST_SKIP: begin
        if (acc) begin
          if (i_eos) begin
            cnt_next   = '0;
            state_next = ST_DONE;
          end else if (cnt_reg <= ONE) begin
            cnt_next   = '0;
            state_next = ST_RUN;
          end else begin
            cnt_next = cnt_reg - ONE;
          end
        end
      end
      ST_DONE: begin
        state_next = ST_DONE;
      end
      default: begin
        state_next = ST_RUN;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_x || i_clear) begin
      state_reg <= ST_RUN;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  lzss_enc_token_reg #(
    .pCodeWidth(pCodeWidth)
  ) u_out (
    .clk       (clk),
    .rst_x     (rst_x),
    .clear     (i_clear),
    .load      (load),
    .ready     (i_ready),
    .load_flag (is_match),
    .load_code (tok_code),
    .load_last (tok_last),
    .valid     (o_valid),
    .flag      (o_flag),
    .code      (o_code),
    .last      (o_last)
  );

endmodule
